// File: rtl/uart_host_bridge.sv
// UART-to-bus debug initiator. A PC sends 'W'/'R' frames over 8N1 serial.
// The bridge issues one 32-bit req/gnt/rvalid transaction per frame and
// answers with 'K', the read data, 'E' on a bus timeout, or '?' for an
// unknown command byte.
module uart_host_bridge #(
  parameter int ClockFrequency   = 50_000_000,
  parameter int BaudRate         = 115_200,
  parameter int ByteTimeoutBauds = 32,
  parameter int RspTimeoutCycles = 1024
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        uart_rx_i,
  output logic        uart_tx_o,
  output logic        host_req_o,
  input  logic        host_gnt_i,
  output logic [31:0] host_addr_o,
  output logic        host_we_o,
  output logic [3:0]  host_be_o,
  output logic [31:0] host_wdata_o,
  input  logic        host_rvalid_i,
  input  logic [31:0] host_rdata_i,
  output logic        busy_o
);

  localparam int ClocksPerBaud     = ClockFrequency / BaudRate;
  localparam int HalfBaud          = ClocksPerBaud / 2;
  localparam int ByteTimeoutCycles = ByteTimeoutBauds * ClocksPerBaud;
  localparam int BaudW             = $clog2(ClocksPerBaud + 1);
  localparam int ByteToW           = $clog2(ByteTimeoutCycles + 1);
  localparam int RspW              = $clog2(RspTimeoutCycles + 1);

  localparam logic [BaudW-1:0]   BaudLast   = BaudW'(ClocksPerBaud - 1);
  localparam logic [BaudW-1:0]   HalfLast   = BaudW'(HalfBaud - 1);
  localparam logic [ByteToW-1:0] ByteToLast = ByteToW'(ByteTimeoutCycles - 1);
  localparam logic [RspW-1:0]    RspLast    = RspW'(RspTimeoutCycles - 1);

  localparam logic [7:0] CmdWrite = 8'h57;
  localparam logic [7:0] CmdRead  = 8'h52;
  localparam logic [7:0] RspOk    = 8'h4B;
  localparam logic [7:0] RspErr   = 8'h45;
  localparam logic [7:0] RspUnk   = 8'h3F;

  // Byte enables are never partial: every access is a full word.
  assign host_be_o = 4'hF;

  // ---------------------------------------------------------------- receiver
  typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;

  rx_state_e        rx_state;
  logic [2:0]       rx_sync;
  logic [BaudW-1:0] rx_cnt;
  logic [2:0]       rx_bit;
  logic [7:0]       rx_shift;
  logic             rx_valid;
  logic [7:0]       rx_byte;
  logic             rx_line;
  logic             rx_fall;

  assign rx_line = rx_sync[1];
  assign rx_fall = rx_sync[2] & ~rx_sync[1];

  // Synchronise the line, qualify the start bit at half a bit, sample mid-bit.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rx_sync  <= 3'b111;
      rx_state <= RxIdle;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
      rx_valid <= 1'b0;
      rx_byte  <= '0;
    end else begin
      rx_sync  <= {rx_sync[1:0], uart_rx_i};
      rx_valid <= 1'b0;
      case (rx_state)
        RxIdle: begin
          if (rx_fall) begin
            rx_state <= RxStart;
            rx_cnt   <= '0;
          end
        end
        RxStart: begin
          if (rx_cnt == HalfLast) begin
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_state <= rx_line ? RxIdle : RxData;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        RxData: begin
          if (rx_cnt == BaudLast) begin
            rx_cnt   <= '0;
            rx_shift <= {rx_line, rx_shift[7:1]};
            rx_bit   <= rx_bit + 1'b1;
            if (rx_bit == 3'd7) rx_state <= RxStop;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        RxStop: begin
          if (rx_cnt == BaudLast) begin
            rx_cnt   <= '0;
            rx_state <= RxIdle;
            // A low stop bit is a framing error: the byte is silently dropped.
            if (rx_line) begin
              rx_valid <= 1'b1;
              rx_byte  <= rx_shift;
            end
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        default: rx_state <= RxIdle;
      endcase
    end
  end

  // ------------------------------------------------------------- transmitter
  logic             tx_active;
  logic [8:0]       tx_shift;
  logic [BaudW-1:0] tx_cnt;
  logic [3:0]       tx_bit;
  logic             tx_last;
  logic             tx_ready;
  logic             tx_load;
  logic             q_valid;
  logic [7:0]       q_byte;

  // Accepting a new byte in the final stop-bit clock keeps frames back-to-back.
  assign tx_last  = tx_active && (tx_bit == 4'd9) && (tx_cnt == BaudLast);
  assign tx_ready = !tx_active || tx_last;
  assign tx_load  = q_valid && tx_ready;

  // Shift out start, 8 data bits LSB first, stop; output is registered.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      uart_tx_o <= 1'b1;
      tx_active <= 1'b0;
      tx_shift  <= '0;
      tx_cnt    <= '0;
      tx_bit    <= '0;
    end else if (tx_load) begin
      uart_tx_o <= 1'b0;
      tx_shift  <= {1'b1, q_byte};
      tx_cnt    <= '0;
      tx_bit    <= '0;
      tx_active <= 1'b1;
    end else if (tx_active) begin
      if (tx_cnt == BaudLast) begin
        tx_cnt <= '0;
        if (tx_bit == 4'd9) begin
          tx_active <= 1'b0;
          uart_tx_o <= 1'b1;
        end else begin
          tx_bit    <= tx_bit + 1'b1;
          uart_tx_o <= tx_shift[0];
          tx_shift  <= {1'b0, tx_shift[8:1]};
        end
      end else begin
        tx_cnt <= tx_cnt + 1'b1;
      end
    end
  end

  // ---------------------------------------------------------- command engine
  typedef enum logic [2:0] {Cmd, Addr, Data, BusReq, BusWait, Resp} state_e;

  state_e             state;
  logic               is_write;
  logic [1:0]         byte_cnt;
  logic [31:0]        addr_sh;
  logic [31:0]        data_sh;
  logic [ByteToW-1:0] byte_to;
  logic [RspW-1:0]    rsp_cnt;
  logic [31:0]        resp_buf;
  logic [2:0]         resp_left;

  // Frame decode, bus handshake with timeout, and reply sequencing.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state        <= Cmd;
      is_write     <= 1'b0;
      byte_cnt     <= '0;
      addr_sh      <= '0;
      data_sh      <= '0;
      byte_to      <= '0;
      rsp_cnt      <= '0;
      resp_buf     <= '0;
      resp_left    <= '0;
      q_valid      <= 1'b0;
      q_byte       <= '0;
      host_req_o   <= 1'b0;
      host_we_o    <= 1'b0;
      host_addr_o  <= '0;
      host_wdata_o <= '0;
      busy_o       <= 1'b0;
    end else begin
      if (tx_load) q_valid <= 1'b0;
      case (state)
        Cmd: begin
          if (rx_valid) begin
            if (rx_byte == CmdWrite || rx_byte == CmdRead) begin
              is_write <= (rx_byte == CmdWrite);
              byte_cnt <= '0;
              byte_to  <= '0;
              state    <= Addr;
              busy_o   <= 1'b1;
            end else begin
              q_valid <= 1'b1;
              q_byte  <= RspUnk;
            end
          end
        end
        Addr, Data: begin
          if (rx_valid) begin
            byte_to  <= '0;
            byte_cnt <= byte_cnt + 2'd1;
            if (state == Addr) addr_sh <= {rx_byte, addr_sh[31:8]};
            else               data_sh <= {rx_byte, data_sh[31:8]};
            if (byte_cnt == 2'd3) begin
              if (state == Addr && is_write) begin
                state <= Data;
              end else begin
                state      <= BusReq;
                host_req_o <= 1'b1;
                host_we_o  <= is_write;
                rsp_cnt    <= '0;
                if (state == Addr) begin
                  host_addr_o <= {rx_byte, addr_sh[31:10], 2'b00};
                end else begin
                  host_addr_o  <= {addr_sh[31:2], 2'b00};
                  host_wdata_o <= {rx_byte, data_sh[31:8]};
                end
              end
            end
          end else if (byte_to == ByteToLast) begin
            state  <= Cmd;
            busy_o <= 1'b0;
          end else begin
            byte_to <= byte_to + 1'b1;
          end
        end
        BusReq: begin
          rsp_cnt <= rsp_cnt + 1'b1;
          if (host_gnt_i) begin
            host_req_o <= 1'b0;
            state      <= BusWait;
          end else if (rsp_cnt >= RspLast) begin
            host_req_o <= 1'b0;
            resp_buf   <= {24'h0, RspErr};
            resp_left  <= 3'd1;
            state      <= Resp;
          end
        end
        BusWait: begin
          rsp_cnt <= rsp_cnt + 1'b1;
          if (host_rvalid_i) begin
            state <= Resp;
            if (host_we_o) begin
              resp_buf  <= {24'h0, RspOk};
              resp_left <= 3'd1;
            end else begin
              resp_buf  <= host_rdata_i;
              resp_left <= 3'd4;
            end
          end else if (rsp_cnt >= RspLast) begin
            resp_buf  <= {24'h0, RspErr};
            resp_left <= 3'd1;
            state     <= Resp;
          end
        end
        Resp: begin
          if (resp_left != 3'd0) begin
            if (!q_valid || tx_load) begin
              q_valid   <= 1'b1;
              q_byte    <= resp_buf[7:0];
              resp_buf  <= {8'h0, resp_buf[31:8]};
              resp_left <= resp_left - 3'd1;
            end
          end else if (!q_valid && !tx_active) begin
            state  <= Cmd;
            busy_o <= 1'b0;
          end
        end
        default: begin
          state  <= Cmd;
          busy_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_host_bridge.sv
// Directed bench for uart_host_bridge at 10 clocks per bit: serial driver,
// serial decoder, simple bus responder and hand-computed expectations.
module tb_uart_host_bridge;
  localparam int Cpb = 10;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        uart_rx = 1'b1;
  logic        uart_tx;
  logic        host_req;
  logic        host_gnt = 1'b0;
  logic [31:0] host_addr;
  logic        host_we;
  logic [3:0]  host_be;
  logic [31:0] host_wdata;
  logic        host_rvalid = 1'b0;
  logic [31:0] host_rdata = 32'h0;
  logic        busy;

  always #10 clk = ~clk;

  uart_host_bridge #(
    .ClockFrequency  (50_000_000),
    .BaudRate        (5_000_000),
    .ByteTimeoutBauds(32),
    .RspTimeoutCycles(1024)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .uart_rx_i    (uart_rx),
    .uart_tx_o    (uart_tx),
    .host_req_o   (host_req),
    .host_gnt_i   (host_gnt),
    .host_addr_o  (host_addr),
    .host_we_o    (host_we),
    .host_be_o    (host_be),
    .host_wdata_o (host_wdata),
    .host_rvalid_i(host_rvalid),
    .host_rdata_i (host_rdata),
    .busy_o       (busy)
  );

  int n_checks = 0;
  int n_errs = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Serial decoder for the bridge's transmit line
  logic [7:0] txq[$];
  bit         mon_act = 0;
  int         mon_cnt = 0;
  int         mon_k = 0;
  logic [7:0] mon_sh = 8'h0;

  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        mon_act = 0;
      end else if (!mon_act) begin
        if (uart_tx === 1'b0) begin
          mon_act = 1;
          mon_cnt = 0;
        end
      end else begin
        mon_cnt++;
        if (mon_cnt >= 5 && (mon_cnt - 5) % Cpb == 0) begin
          mon_k = (mon_cnt - 5) / Cpb;
          if (mon_k == 0) begin
            if (uart_tx !== 1'b0) mon_act = 0;
          end else if (mon_k <= 8) begin
            mon_sh = {uart_tx, mon_sh[7:1]};
          end else begin
            txq.push_back(mon_sh);
            mon_act = 0;
          end
        end
      end
    end
  end

  // Bus responder: grant after gnt_delay req cycles, rvalid the cycle after grant
  int          gnt_delay = 0;
  bit          rv_en = 1;
  logic [31:0] rv_data = 32'h0;
  bit          rv_pend = 0;
  int          req_cyc = 0;
  int          req_held = 0;
  int          req_count = 0;
  int          addr_moves = 0;
  logic [31:0] rec_addr = 32'h0;
  logic [31:0] rec_wdata = 32'h0;
  logic        rec_we = 1'b0;
  logic [3:0]  rec_be = 4'h0;

  initial begin
    forever begin
      @(negedge clk);
      host_gnt = 1'b0;
      host_rvalid = 1'b0;
      if (rv_pend) begin
        host_rvalid = rv_en;
        host_rdata = rv_data;
        rv_pend = 0;
      end
      if (host_req === 1'b1) begin
        req_cyc++;
        if (req_cyc == 1) begin
          req_count++;
          rec_addr = host_addr;
          rec_we = host_we;
          rec_wdata = host_wdata;
          rec_be = host_be;
        end else if (host_addr !== rec_addr || host_wdata !== rec_wdata || host_we !== rec_we) begin
          addr_moves++;
        end
        if (req_cyc > gnt_delay) begin
          host_gnt = 1'b1;
          rv_pend = 1;
        end
      end else begin
        if (req_cyc != 0) req_held = req_cyc;
        req_cyc = 0;
      end
    end
  end

  logic [7:0] frame[$];

  task automatic send_byte(input logic [7:0] b, input logic stop);
    @(negedge clk);
    uart_rx = 1'b0;
    repeat (Cpb) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (Cpb) @(negedge clk);
    end
    uart_rx = stop;
    repeat (Cpb) @(negedge clk);
    uart_rx = 1'b1;
  endtask

  task automatic send_frame();
    for (int i = 0; i < frame.size(); i++) send_byte(frame[i], 1'b1);
  endtask

  task automatic wait_tx(input string tag, input int n, input int budget);
    int t = 0;
    while (txq.size() < n && t < budget) begin
      @(negedge clk);
      t++;
    end
    check(tag, txq.size(), n);
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int t = 0;
    while (busy !== 1'b0 && t < budget) begin
      @(negedge clk);
      t++;
    end
    check(tag, 32'(busy), 32'h0);
  endtask

  function automatic logic [31:0] tx_byte(input int i);
    if (i < txq.size()) return {24'h0, txq[i]};
    return 'x;
  endfunction

  function automatic logic [31:0] tx_word(input int first);
    if (first + 4 <= txq.size())
      return {txq[first+3], txq[first+2], txq[first+1], txq[first]};
    return 'x;
  endfunction

  int base;
  int t;

  initial begin
    // Reset values
    repeat (5) @(negedge clk);
    check("rst_tx", 32'(uart_tx), 32'h1);
    check("rst_req", 32'(host_req), 32'h0);
    check("rst_we", 32'(host_we), 32'h0);
    check("rst_addr", host_addr, 32'h0);
    check("rst_wdata", host_wdata, 32'h0);
    check("rst_be", 32'(host_be), 32'hF);
    check("rst_busy", 32'(busy), 32'h0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Write, grant in the first req cycle, rvalid one cycle later
    gnt_delay = 0; rv_en = 1; rv_data = 32'h0;
    base = req_count; txq.delete();
    frame = '{8'h57, 8'h10, 8'h00, 8'h00, 8'h20, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    send_frame();
    wait_tx("wr_tx_cnt", 1, 1000);
    check("wr_reqs", req_count - base, 1);
    check("wr_addr", rec_addr, 32'h2000_0010);
    check("wr_we", 32'(rec_we), 32'h1);
    check("wr_wdata", rec_wdata, 32'hDEAD_BEEF);
    check("wr_be", 32'(rec_be), 32'hF);
    check("wr_req_len", req_held, 1);
    check("wr_reply", tx_byte(0), 32'h4B);
    wait_idle("wr_idle", 100);

    // Read with grant delayed 5 cycles
    gnt_delay = 5; rv_data = 32'h0000_0003;
    base = req_count; addr_moves = 0; txq.delete();
    frame = '{8'h52, 8'h08, 8'h00, 8'h00, 8'h80};
    send_frame();
    wait_tx("rd_tx_cnt", 4, 1500);
    check("rd_reqs", req_count - base, 1);
    check("rd_addr", rec_addr, 32'h8000_0008);
    check("rd_we", 32'(rec_we), 32'h0);
    check("rd_req_len", req_held, 6);
    check("rd_addr_stable", addr_moves, 0);
    check("rd_reply", tx_word(0), 32'h0000_0003);
    wait_idle("rd_idle", 100);

    // Bus timeout: grant never arrives
    gnt_delay = 100000;
    base = req_count; txq.delete();
    frame = '{8'h52, 8'h04, 8'h00, 8'h00, 8'h00};
    send_frame();
    wait_tx("to_tx_cnt", 1, 1500);
    check("to_reqs", req_count - base, 1);
    check("to_req_len", req_held, 1024);
    check("to_reply", tx_byte(0), 32'h45);
    wait_idle("to_idle", 100);
    gnt_delay = 0;

    // Unknown command, then a framing-error byte followed by a valid read
    base = req_count; txq.delete();
    frame = '{8'h41};
    send_frame();
    wait_tx("unk_tx_cnt", 1, 300);
    check("unk_reply", tx_byte(0), 32'h3F);
    check("unk_busy", 32'(busy), 32'h0);
    check("unk_reqs", req_count - base, 0);
    send_byte(8'h52, 1'b0);
    repeat (2 * Cpb) @(negedge clk);
    rv_data = 32'h1234_5678;
    frame = '{8'h52, 8'h0F, 8'h00, 8'h00, 8'h00};
    send_frame();
    wait_tx("fe_tx_cnt", 5, 1500);
    check("fe_reqs", req_count - base, 1);
    check("fe_addr", rec_addr, 32'h0000_000C);
    check("fe_reply", tx_word(1), 32'h1234_5678);
    wait_idle("fe_idle", 100);

    // Partial write abandoned by the inter-byte timeout, then a read
    base = req_count; txq.delete();
    rv_data = 32'hCAFE_F00D;
    frame = '{8'h57, 8'h11, 8'h22};
    send_frame();
    repeat (40 * Cpb) @(negedge clk);
    check("ito_busy", 32'(busy), 32'h0);
    frame = '{8'h52, 8'h20, 8'h00, 8'h00, 8'h00};
    send_frame();
    wait_tx("ito_tx_cnt", 4, 1500);
    check("ito_reqs", req_count - base, 1);
    check("ito_we", 32'(rec_we), 32'h0);
    check("ito_addr", rec_addr, 32'h0000_0020);
    check("ito_reply", tx_word(0), 32'hCAFE_F00D);
    wait_idle("ito_idle", 100);

    // Reset while req is held
    gnt_delay = 100000;
    frame = '{8'h52, 8'h00, 8'h01, 8'h00, 8'h00};
    send_frame();
    t = 0;
    while (host_req !== 1'b1 && t < 200) begin
      @(negedge clk);
      t++;
    end
    repeat (3) @(negedge clk);
    check("rq_pre_req", 32'(host_req), 32'h1);
    check("rq_pre_busy", 32'(busy), 32'h1);
    rst_n = 1'b0;
    #1;
    check("rq_rst_req", 32'(host_req), 32'h0);
    check("rq_rst_busy", 32'(busy), 32'h0);
    check("rq_rst_tx", 32'(uart_tx), 32'h1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    gnt_delay = 0;
    repeat (5) @(negedge clk);

    // Reset while a reply byte is on the line
    rv_data = 32'h0;
    frame = '{8'h52, 8'h40, 8'h00, 8'h00, 8'h00};
    send_frame();
    t = 0;
    while (uart_tx !== 1'b0 && t < 300) begin
      @(negedge clk);
      t++;
    end
    repeat (30) @(negedge clk);
    check("tx_pre_line", 32'(uart_tx), 32'h0);
    check("tx_pre_busy", 32'(busy), 32'h1);
    rst_n = 1'b0;
    #1;
    check("tx_rst_line", 32'(uart_tx), 32'h1);
    check("tx_rst_busy", 32'(busy), 32'h0);
    check("tx_rst_req", 32'(host_req), 32'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Bridge answers normally after reset
    txq.delete();
    frame = '{8'h41};
    send_frame();
    wait_tx("post_tx_cnt", 1, 300);
    check("post_reply", tx_byte(0), 32'h3F);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", n_errs, n_checks);
    $fatal(1);
  end

endmodule
